// File: rtl/aes_pkg.sv
// Shared AES byte types, FSM state encoding and forward/inverse S-box tables.
// The inverse table is only referenced when AES_INV_SBOX_EN is defined.
package aes_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } subbytes_state_e;

  localparam byte_t SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box for one byte. With AES_INV_SBOX_EN defined the
// inverse table is also present and selected by inv; otherwise inv is ignored.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t in_byte,
  input  logic  inv,
  output byte_t out_byte
);

`ifdef AES_INV_SBOX_EN
  assign out_byte = inv ? SBOX_INV[in_byte] : SBOX_FWD[in_byte];
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign out_byte   = SBOX_FWD[in_byte];
`endif

endmodule

// File: rtl/aes64_subbytes_seq.sv
// Sequential SubBytes over a 64-bit half-state, BYTES_PER_CYCLE shared S-boxes.
// Optional inverse substitution is enabled by defining AES_INV_SBOX_EN.
module aes64_subbytes_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_inv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  localparam int NUM_STEPS = 8 / BYTES_PER_CYCLE;
  localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 ||
        BYTES_PER_CYCLE == 4 || BYTES_PER_CYCLE == 8)) begin : g_bad_bpc
    $error("aes64_subbytes_seq: BYTES_PER_CYCLE must be 1, 2, 4 or 8");
  end

  subbytes_state_e   state_reg, state_next;
  logic [STEP_W-1:0] step_reg;
  byte_t             data_reg [8];
  byte_t             res_reg  [8];
  byte_t             res_next [8];
  logic              inv_reg;
  logic [63:0]       res_flat;
  logic [63:0]       out_data_reg;
  logic [2:0]        step_base;
  byte_t             sbox_out [BYTES_PER_CYCLE];
  logic              accept;
  logic              last_step;

  assign step_base = 3'(int'(step_reg) * BYTES_PER_CYCLE);
  assign last_step = (step_reg == LAST_STEP);
  assign accept    = in_valid && in_ready;

  // Lane gi of each step handles byte step*BPC+gi, so low bytes finish first.
  for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_sbox
    logic [2:0] lane;
    assign lane = step_base + 3'(gi);
    aes_sbox u_sbox (
      .in_byte  (data_reg[lane]),
      .inv      (inv_reg),
      .out_byte (sbox_out[gi])
    );
  end

  always_comb begin
    res_next = res_reg;
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      res_next[step_base + 3'(i)] = sbox_out[i];
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_pack
    assign res_flat[gi*8 +: 8] = res_next[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = BUSY;
      BUSY: if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = in_valid ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready deliberately ignores in_valid so upstream can wait on it freely.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign out_data = out_data_reg;

  // The output register is only loaded on the final step, so out_data is stable
  // from DONE entry until the next operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_reg     <= '0;
      inv_reg      <= 1'b0;
      out_data_reg <= '0;
      for (int i = 0; i < 8; i++) begin
        data_reg[i] <= '0;
        res_reg[i]  <= '0;
      end
    end else if (accept) begin
      step_reg <= '0;
      inv_reg  <= in_inv;
      for (int i = 0; i < 8; i++) begin
        data_reg[i] <= in_data[i*8 +: 8];
        res_reg[i]  <= '0;
      end
    end else if (state_reg == BUSY) begin
      res_reg <= res_next;
      if (last_step) begin
        step_reg     <= '0;
        out_data_reg <= res_flat;
      end else begin
        step_reg <= step_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes64_subbytes_seq.sv
// Bench for aes64_subbytes_seq: GF(2^8)-derived S-box model, cycle scoreboard,
// directed vectors; extra instances cover BYTES_PER_CYCLE = 1, 4, 8 latency.
module tb_aes64_subbytes_seq;

  localparam int NUM = 4;
`ifdef AES_INV_SBOX_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_inv = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;

  logic [2:0]  x_in_valid = '0;
  logic [2:0]  x_in_ready;
  logic [2:0]  x_out_valid;
  logic        x_out_ready = 1'b1;
  logic [63:0] x_out_data [3];

  always #5 clk = ~clk;

  aes64_subbytes_seq #(.BYTES_PER_CYCLE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_x
    localparam int XB = (gi == 0) ? 1 : (gi == 1) ? 4 : 8;
    aes64_subbytes_seq #(.BYTES_PER_CYCLE(XB)) u_x (
      .clk(clk), .rst(rst), .in_valid(x_in_valid[gi]), .in_ready(x_in_ready[gi]),
      .in_data(in_data), .in_inv(in_inv), .out_valid(x_out_valid[gi]),
      .out_ready(x_out_ready), .out_data(x_out_data[gi])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---- S-box model: multiplicative inverse in GF(2^8) plus affine map ----
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(logic [7:0] x);
    logic [7:0] r = 8'h01;
    if (x == 8'h00) r = 8'h00;
    else for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ rol8(r, 1) ^ rol8(r, 2) ^ rol8(r, 3) ^ rol8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [63:0] model(logic [63:0] d, logic inv);
    logic [63:0] r;
    for (int i = 0; i < 8; i++)
      r[i*8 +: 8] = (inv && INV_EN) ? inv_tab[d[i*8 +: 8]] : fwd_tab[d[i*8 +: 8]];
    return r;
  endfunction

  // ---- scoreboard: expected result and accept-edge index per operation ----
  typedef struct {
    logic [63:0] exp;
    int          acc;
  } item_t;
  item_t       q[$];
  int          cyc = 0;
  logic [63:0] last_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      bit done_m;
      bit ready_m;
      done_m  = (q.size() > 0) && (cyc >= q[0].acc + NUM);
      ready_m = (q.size() == 0) || (done_m && out_ready);
      chk("in_ready", 64'(in_ready), 64'(ready_m));
      chk("out_valid", 64'(out_valid), 64'(done_m));
      if (done_m && out_valid) chk("out_data", out_data, q[0].exp);
      if (done_m && out_ready) begin
        last_out = out_data;
        void'(q.pop_front());
      end
      if (in_valid && ready_m) q.push_back('{exp: model(in_data, in_inv), acc: cyc + 1});
    end
  end

  // ---- stimulus helpers ----
  task automatic send(logic [63:0] d, logic inv);
    bit got = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) chk("send_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (q.size() == 0) begin empty = 1; break; end
    end
    if (!empty) chk("drain_timeout", 64'(empty), 64'd1);
  endtask

  task automatic lat_test(int k, int bpc, logic [63:0] exp);
    int n = 0;
    bit hit = 0;
    @(posedge clk); #1;
    x_in_valid[k] = 1'b1;
    @(negedge clk);
    chk($sformatf("x%0d_in_ready", bpc), 64'(x_in_ready[k]), 64'd1);
    @(posedge clk); #1;
    x_in_valid[k] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); n++; #1;
      if (x_out_valid[k]) begin hit = 1; break; end
    end
    chk($sformatf("x%0d_latency", bpc), 64'(n), 64'(8 / bpc));
    chk($sformatf("x%0d_data", bpc), x_out_data[k], exp);
    repeat (2) @(posedge clk);
    chk($sformatf("x%0d_seen", bpc), 64'(hit), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_calc(8'(i));
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
    chk("model_s00", 64'(fwd_tab[8'h00]), 64'h63);
    chk("model_s53", 64'(fwd_tab[8'h53]), 64'hed);
    chk("model_sff", 64'(fwd_tab[8'hff]), 64'h16);
    chk("model_i63", 64'(inv_tab[8'h63]), 64'h00);
    chk("model_ied", 64'(inv_tab[8'hed]), 64'h53);
    chk("model_vec", model(64'h0706050403020100, 1'b0), 64'hc56f6bf27b777c63);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // 1: all-zero forward
    send(64'h0, 1'b0);
    drain();
    chk("t1_zero", last_out, 64'h6363636363636363);

    // 2: ascending bytes, then the other widths
    send(64'h0706050403020100, 1'b0);
    drain();
    chk("t2_vec", last_out, 64'hc56f6bf27b777c63);
    in_data = 64'h0706050403020100;
    lat_test(0, 1, 64'hc56f6bf27b777c63);
    lat_test(1, 4, 64'hc56f6bf27b777c63);
    lat_test(2, 8, 64'hc56f6bf27b777c63);

    // 3: stall in DONE, then back-to-back accept
    out_ready = 1'b0;
    send(64'h0, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_ready", 64'(in_ready), 64'd0);
      chk("t3_hold_data", out_data, 64'h6363636363636363);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = '1;
    @(negedge clk);
    chk("t3_b2b_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("t3_ff", last_out, 64'h1616161616161616);

    // 4: in_valid while BUSY must be ignored
    send(64'h0011223344556677, 1'b0);
    in_valid = 1'b1; in_data = 64'h5353535353535353;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    chk("t4_busy_ignore", last_out, 64'h638293c31bfc33f5);
    repeat (6) @(posedge clk);

    // 5: reset mid-operation
    send(64'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_out_data", out_data, 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // 6: inverse select (forward when the inverse table is not built)
    send(64'h63636363636363ED, 1'b1);
    drain();
`ifdef AES_INV_SBOX_EN
    chk("t6_inv", last_out, 64'h0000000000000053);
`else
    chk("t6_inv", last_out, 64'hfbfbfbfbfbfbfb55);
`endif
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
